// File: rtl/awg_wave_gen.sv
// awg_wave_gen: phase-accumulator waveform core producing sawtooth and sine on
// two channels (B offset by a programmable phase) plus an LFSR noise source.
// All wave outputs are 14-bit offset-binary, midscale 8192.
module awg_wave_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] freq,
  input  logic [3:0]  amp,
  input  logic [8:0]  phase,
  output logic [13:0] saw_a,
  output logic [13:0] saw_b,
  output logic [13:0] sin_a,
  output logic [13:0] sin_b,
  output logic [13:0] noise
);

  localparam int unsigned DW = 14;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 16;
  localparam logic [DW-1:0] MID = 14'd8192;
  localparam logic [3:0]    AMP_MAX = 4'd8;
  localparam logic [AW-1:0] DEG_STEP = 16'd182;

  // Quarter-wave sine magnitude: round(8191*sin(2*pi*(i+0.5)/256)), i = 0..63
  function automatic logic [12:0] q_lut(input logic [5:0] i);
    logic [12:0] q;
    case (i)
      6'd0:  q = 13'd101;   6'd1:  q = 13'd301;   6'd2:  q = 13'd502;   6'd3:  q = 13'd703;
      6'd4:  q = 13'd903;   6'd5:  q = 13'd1102;  6'd6:  q = 13'd1301;  6'd7:  q = 13'd1499;
      6'd8:  q = 13'd1696;  6'd9:  q = 13'd1893;  6'd10: q = 13'd2088;  6'd11: q = 13'd2281;
      6'd12: q = 13'd2474;  6'd13: q = 13'd2665;  6'd14: q = 13'd2854;  6'd15: q = 13'd3041;
      6'd16: q = 13'd3227;  6'd17: q = 13'd3411;  6'd18: q = 13'd3593;  6'd19: q = 13'd3772;
      6'd20: q = 13'd3950;  6'd21: q = 13'd4124;  6'd22: q = 13'd4297;  6'd23: q = 13'd4467;
      6'd24: q = 13'd4634;  6'd25: q = 13'd4798;  6'd26: q = 13'd4960;  6'd27: q = 13'd5118;
      6'd28: q = 13'd5274;  6'd29: q = 13'd5426;  6'd30: q = 13'd5575;  6'd31: q = 13'd5720;
      6'd32: q = 13'd5863;  6'd33: q = 13'd6001;  6'd34: q = 13'd6136;  6'd35: q = 13'd6267;
      6'd36: q = 13'd6395;  6'd37: q = 13'd6519;  6'd38: q = 13'd6638;  6'd39: q = 13'd6754;
      6'd40: q = 13'd6866;  6'd41: q = 13'd6973;  6'd42: q = 13'd7077;  6'd43: q = 13'd7176;
      6'd44: q = 13'd7271;  6'd45: q = 13'd7361;  6'd46: q = 13'd7447;  6'd47: q = 13'd7528;
      6'd48: q = 13'd7605;  6'd49: q = 13'd7678;  6'd50: q = 13'd7745;  6'd51: q = 13'd7809;
      6'd52: q = 13'd7867;  6'd53: q = 13'd7921;  6'd54: q = 13'd7969;  6'd55: q = 13'd8013;
      6'd56: q = 13'd8053;  6'd57: q = 13'd8087;  6'd58: q = 13'd8116;  6'd59: q = 13'd8141;
      6'd60: q = 13'd8161;  6'd61: q = 13'd8176;  6'd62: q = 13'd8185;  default: q = 13'd8190;
    endcase
    return q;
  endfunction

  // Full-wave sine from the top 8 address bits: quadrant mirrors index and/or sign
  function automatic logic [DW-1:0] sine_raw(input logic [7:0] ph);
    logic [5:0]  idx;
    logic [12:0] mag;
    idx = ph[6] ? ~ph[5:0] : ph[5:0];
    mag = q_lut(idx);
    return ph[7] ? (MID - 14'(mag)) : (MID + 14'(mag));
  endfunction

  // Scale around midscale: 8192 + floor((raw-8192)*a/8)
  function automatic logic [DW-1:0] scale_amp(input logic [DW-1:0] raw, input logic [3:0] a);
    logic signed [18:0] d;
    logic signed [18:0] p;
    logic signed [18:0] r;
    d = signed'({5'b0, raw}) - 19'sd8192;
    p = d * signed'({15'b0, a});
    r = (p >>> 3) + 19'sd8192;
    return 14'(r);
  endfunction

  logic [AW-1:0] acc;
  logic [LW-1:0] lfsr;
  logic [DW-1:0] saw_a_raw, saw_b_raw, sin_a_raw, sin_b_raw;

  logic [AW-1:0] off;
  logic [DW-1:0] addr_b_hi;
  logic [3:0]    amp_eff;
  logic          lfsr_fb;

  // Channel-B address, amplitude clamp and LFSR feedback
  always_comb begin
    off       = 16'(phase) * DEG_STEP;
    addr_b_hi = 14'((acc + off) >> 2);
    amp_eff   = (amp > AMP_MAX) ? AMP_MAX : amp;
    lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  // Phase accumulator, wraps mod 2^16, holds when en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + 16'(freq);
    end
  end

  // Free-running noise LFSR, independent of en
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Raw waveform stage: both channels from the same accumulator sample
  always_ff @(posedge clk) begin
    if (rst) begin
      saw_a_raw <= MID;
      saw_b_raw <= MID;
      sin_a_raw <= MID;
      sin_b_raw <= MID;
    end else begin
      saw_a_raw <= acc[15:2];
      saw_b_raw <= addr_b_hi;
      sin_a_raw <= sine_raw(acc[15:8]);
      sin_b_raw <= sine_raw(addr_b_hi[13:6]);
    end
  end

  // Amplitude scaling stage driving the DAC outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      saw_a <= MID;
      saw_b <= MID;
      sin_a <= MID;
      sin_b <= MID;
    end else begin
      saw_a <= scale_amp(saw_a_raw, amp_eff);
      saw_b <= scale_amp(saw_b_raw, amp_eff);
      sin_a <= scale_amp(sin_a_raw, amp_eff);
      sin_b <= scale_amp(sin_b_raw, amp_eff);
    end
  end

  assign noise = lfsr[15:2];

endmodule

// File: tb/tb_awg_wave_gen.sv
// tb_awg_wave_gen: scoreboard bench for awg_wave_gen. A reference model derived
// from plain arithmetic (real-valued sine table, integer floor scaling, LFSR
// recurrence) predicts each edge's outputs; a monitor pops and compares.
module tb_awg_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] freq;
  logic [3:0]  amp;
  logic [8:0]  phase;
  logic [13:0] saw_a, saw_b, sin_a, sin_b, noise;

  awg_wave_gen #(.LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .freq  (freq),
    .amp   (amp),
    .phase (phase),
    .saw_a (saw_a),
    .saw_b (saw_b),
    .sin_a (sin_a),
    .sin_b (sin_b),
    .noise (noise)
  );

  always #5 clk = ~clk;

  typedef struct {
    int saw_a;
    int saw_b;
    int sin_a;
    int sin_b;
    int noise;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_mon  = 0;
  int   q_tab[64];

  // Reference model state
  int m_acc;
  int m_s;
  int m_raw[4];   // saw_a, saw_b, sin_a, sin_b
  int m_out[4];

  function automatic int sine_of(int addr);
    int quad;
    int i;
    quad = addr / 16384;
    i    = (addr % 16384) / 256;
    case (quad)
      0:       return 8192 + q_tab[i];
      1:       return 8192 + q_tab[63 - i];
      2:       return 8192 - q_tab[i];
      default: return 8192 - q_tab[63 - i];
    endcase
  endfunction

  function automatic int scale_of(int raw, int a_in);
    int a;
    int p;
    int fl;
    a  = (a_in > 8) ? 8 : a_in;
    p  = (raw - 8192) * a;
    fl = (p >= 0) ? (p / 8) : -((-p + 7) / 8);
    return 8192 + fl;
  endfunction

  function automatic int lfsr_next(int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) & 16'hFFFF) | fb;
  endfunction

  task automatic model_step(input int r, input int e, input int f, input int p, input int a);
    int addr_b;
    if (r != 0) begin
      m_acc = 0;
      m_s   = 16'hACE1;
      for (int k = 0; k < 4; k++) begin
        m_raw[k] = 8192;
        m_out[k] = 8192;
      end
    end else begin
      for (int k = 0; k < 4; k++) m_out[k] = scale_of(m_raw[k], a);
      addr_b   = (m_acc + (p * 182) % 65536) % 65536;
      m_raw[0] = m_acc / 4;
      m_raw[1] = addr_b / 4;
      m_raw[2] = sine_of(m_acc);
      m_raw[3] = sine_of(addr_b);
      if (e != 0) m_acc = (m_acc + f) % 65536;
      m_s = lfsr_next(m_s);
    end
  endtask

  task automatic cycle(input int r, input int e, input int f, input int p, input int a);
    exp_t x;
    rst   = (r != 0);
    en    = (e != 0);
    freq  = 12'(f);
    phase = 9'(p);
    amp   = 4'(a);
    model_step(r, e, f, p, a);
    x.saw_a = m_out[0];
    x.saw_b = m_out[1];
    x.sin_a = m_out[2];
    x.sin_b = m_out[3];
    x.noise = m_s / 4;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_mon, got, want);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc_mon++;
        check("saw_a", int'(saw_a), e.saw_a);
        check("saw_b", int'(saw_b), e.saw_b);
        check("sin_a", int'(sin_a), e.sin_a);
        check("sin_b", int'(sin_b), e.sin_b);
        check("noise", int'(noise), e.noise);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    real pi_r;
    pi_r = 3.14159265358979;
    for (int i = 0; i < 64; i++)
      q_tab[i] = $rtoi(8191.0 * $sin(2.0 * pi_r * (real'(i) + 0.5) / 256.0) + 0.5);
    m_acc = 0;
    m_s   = 16'hACE1;
    for (int k = 0; k < 4; k++) begin
      m_raw[k] = 8192;
      m_out[k] = 8192;
    end

    // Reset, then static address with assorted channel-B offsets
    repeat (2) cycle(1, 0, 0, 0, 8);
    repeat (4) cycle(0, 1, 0, 0, 8);
    repeat (3) cycle(0, 1, 0, 90, 8);
    repeat (3) cycle(0, 1, 0, 180, 8);
    repeat (3) cycle(0, 1, 0, 359, 8);
    // Sweep through all quadrants and across the wrap
    repeat (36) cycle(0, 1, 2048, 0, 8);
    // Amplitude codes: half, zero, clamped
    repeat (10) cycle(0, 1, 2048, 45, 4);
    repeat (6)  cycle(0, 1, 2048, 45, 0);
    repeat (6)  cycle(0, 1, 2048, 45, 15);
    // Freeze, resume, reset mid-sweep
    repeat (6) cycle(0, 0, 2048, 45, 8);
    repeat (4) cycle(0, 1, 2048, 45, 8);
    cycle(1, 1, 2048, 45, 8);
    repeat (4) cycle(0, 1, 2048, 45, 8);
    // Fast sweep with odd step for repeated wraps
    repeat (40) cycle(0, 1, 4095, 300, 8);

    // Randomized operation
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 511)),
            int'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
